// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// default cycle counts for the 100 MHz reference clock.
package pll_reset_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    CORE_UP   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES           = 2;
  localparam int DEF_PLL_RST_CYCLES        = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES   = 100000;
  localparam int DEF_LOCK_STABLE_CYCLES    = 1024;
  localparam int DEF_CORE_TO_PERIPH_CYCLES = 64;
  localparam int DEF_CNT_W                 = 17;

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Multi-flop single-bit synchroniser with synchronous active-low clear.
// Also used to bring reset releases into the PLL output clock domains.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-on / lock-loss reset controller. Runs on the free-running reference
// clock, holds the PLL in reset, waits for lock, then releases core and
// peripheral resets in order. Retries on lock timeout.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES           = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES        = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES   = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES    = DEF_LOCK_STABLE_CYCLES,
  parameter int CORE_TO_PERIPH_CYCLES = DEF_CORE_TO_PERIPH_CYCLES,
  parameter int CNT_W                 = DEF_CNT_W
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               core_rst_n,
  output logic               periph_rst_n,
  output logic               ready,
  output logic [STATE_W-1:0] state_o,
  output logic [7:0]         retry_cnt
);

  localparam logic [CNT_W-1:0] PLL_RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C2P_LOAD     = CNT_W'(CORE_TO_PERIPH_CYCLES - 1);

  logic             lock_s;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             retry_inc;
  logic             pll_rst_d;
  logic             core_rst_n_d;
  logic             periph_rst_n_d;
  logic             ready_d;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst),
    .d    (pll_locked),
    .q    (lock_s)
  );

  // State, shared down-counter and saturating retry counter.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state     <= PLL_RESET;
      cnt       <= PLL_RST_LOAD;
      retry_cnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (retry_inc && (retry_cnt != '1)) begin
        retry_cnt <= retry_cnt + 8'd1;
      end
    end
  end

  // Next state and counter reload; lock loss takes priority everywhere after WAIT_LOCK.
  always_comb begin
    state_next = state;
    cnt_next   = cnt - CNT_W'(1);
    retry_inc  = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt == '0) begin
          state_next = WAIT_LOCK;
          cnt_next   = TIMEOUT_LOAD;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABILIZE;
          cnt_next   = STABLE_LOAD;
        end else if (cnt == '0) begin
          state_next = PLL_RESET;
          cnt_next   = PLL_RST_LOAD;
          retry_inc  = 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = TIMEOUT_LOAD;
          retry_inc  = 1'b1;
        end else if (cnt == '0) begin
          state_next = CORE_UP;
          cnt_next   = C2P_LOAD;
        end
      end
      CORE_UP: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = TIMEOUT_LOAD;
          retry_inc  = 1'b1;
        end else if (cnt == '0) begin
          state_next = RUN;
          cnt_next   = cnt;
        end
      end
      RUN: begin
        cnt_next = cnt;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          cnt_next   = TIMEOUT_LOAD;
          retry_inc  = 1'b1;
        end
      end
      default: begin
        state_next = PLL_RESET;
        cnt_next   = PLL_RST_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    pll_rst_d      = (state_next == PLL_RESET);
    core_rst_n_d   = (state_next == CORE_UP) || (state_next == RUN);
    periph_rst_n_d = (state_next == RUN);
    ready_d        = (state_next == RUN);
  end

  // Registered outputs keep the resets glitch-free.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      pll_rst      <= 1'b1;
      core_rst_n   <= 1'b0;
      periph_rst_n <= 1'b0;
      ready        <= 1'b0;
    end else begin
      pll_rst      <= pll_rst_d;
      core_rst_n   <= core_rst_n_d;
      periph_rst_n <= periph_rst_n_d;
      ready        <= ready_d;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with shortened cycle counts.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_rst_n;
  logic       periph_rst_n;
  logic       ready;
  logic [2:0] state_o;
  logic [7:0] retry_cnt;

  int passed;
  int total;

  pll_reset_sequencer #(
    .SYNC_STAGES          (2),
    .PLL_RST_CYCLES       (4),
    .LOCK_TIMEOUT_CYCLES  (50),
    .LOCK_STABLE_CYCLES   (20),
    .CORE_TO_PERIPH_CYCLES(8),
    .CNT_W                (17)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .core_rst_n  (core_rst_n),
    .periph_rst_n(periph_rst_n),
    .ready       (ready),
    .state_o     (state_o),
    .retry_cnt   (retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pll_locked = 1'b0;
    repeat (3) tick();
    total++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else passed++;
    total++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); else passed++;
    total++; if (core_rst_n !== 1'b0) $display("FAIL reset_core: got %b expected 0", core_rst_n); else passed++;
    total++; if (periph_rst_n !== 1'b0 || ready !== 1'b0)
      $display("FAIL reset_periph_ready: got %b%b expected 00", periph_rst_n, ready); else passed++;
    total++; if (retry_cnt !== 8'd0) $display("FAIL reset_retry: got %0d expected 0", retry_cnt); else passed++;
  endtask

  task automatic test_bringup();
    int n;
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pll_rst === 1'b1 && n < 20);
    total++; if (n != 4) $display("FAIL bringup_pll_rst_len: got %0d expected 4", n); else passed++;
    total++; if (state_o !== 3'd1) $display("FAIL bringup_wait_state: got %0d expected 1", state_o); else passed++;
    repeat (10) tick();
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (core_rst_n !== 1'b1 && n < 100);
    total++; if (n < 21 || n > 23) $display("FAIL bringup_core_latency: got %0d expected 21..23", n); else passed++;
    total++; if (state_o !== 3'd3 || periph_rst_n !== 1'b0 || pll_rst !== 1'b0)
      $display("FAIL bringup_core_up: got state %0d periph %b pll_rst %b expected 3 0 0", state_o, periph_rst_n, pll_rst); else passed++;
    n = 0;
    do begin tick(); n++; end while (periph_rst_n !== 1'b1 && n < 40);
    total++; if (n != 8) $display("FAIL bringup_periph_delay: got %0d expected 8", n); else passed++;
    total++; if (ready !== 1'b1 || state_o !== 3'd4)
      $display("FAIL bringup_run: got ready %b state %0d expected 1 4", ready, state_o); else passed++;
    total++; if (retry_cnt !== 8'd0) $display("FAIL bringup_retry: got %0d expected 0", retry_cnt); else passed++;
  endtask

  task automatic test_lock_loss_run();
    int n;
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (core_rst_n !== 1'b0 && n < 10);
    total++; if (n > 3) $display("FAIL loss_core_latency: got %0d expected <=3", n); else passed++;
    total++; if (periph_rst_n !== 1'b0 || ready !== 1'b0)
      $display("FAIL loss_periph_ready: got %b%b expected 00", periph_rst_n, ready); else passed++;
    total++; if (pll_rst !== 1'b0 || state_o !== 3'd1)
      $display("FAIL loss_wait: got pll_rst %b state %0d expected 0 1", pll_rst, state_o); else passed++;
    total++; if (retry_cnt !== 8'd1) $display("FAIL loss_retry: got %0d expected 1", retry_cnt); else passed++;
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (core_rst_n !== 1'b1 && n < 100);
    total++; if (n < 21 || n > 23) $display("FAIL relock_core_latency: got %0d expected 21..23", n); else passed++;
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 40);
    total++; if (n != 8) $display("FAIL relock_ready_delay: got %0d expected 8", n); else passed++;
    total++; if (retry_cnt !== 8'd1) $display("FAIL relock_retry: got %0d expected 1", retry_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (core_rst_n !== 1'b0 && n < 10);
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (core_rst_n !== 1'b1 && n < 100);
    total++; if (state_o !== 3'd3 || retry_cnt !== 8'd2)
      $display("FAIL mid_pre: got state %0d retry %0d expected 3 2", state_o, retry_cnt); else passed++;
    rst = 1'b0;
    tick();
    total++; if (state_o !== 3'd0 || pll_rst !== 1'b1)
      $display("FAIL mid_state: got state %0d pll_rst %b expected 0 1", state_o, pll_rst); else passed++;
    total++; if (core_rst_n !== 1'b0 || periph_rst_n !== 1'b0 || ready !== 1'b0)
      $display("FAIL mid_resets: got %b%b%b expected 000", core_rst_n, periph_rst_n, ready); else passed++;
    total++; if (retry_cnt !== 8'd0) $display("FAIL mid_retry: got %0d expected 0", retry_cnt); else passed++;
  endtask

  task automatic test_glitch_stabilize();
    int n;
    logic core_early;
    logic saw_wait;
    core_early = 1'b0;
    saw_wait = 1'b0;
    rst = 1'b0;
    pll_locked = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 20);
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (state_o !== 3'd2 && n < 10);
    total++; if (state_o !== 3'd2) $display("FAIL glitch_enter_stab: got %0d expected 2", state_o); else passed++;
    repeat (10) begin tick(); if (core_rst_n !== 1'b0) core_early = 1'b1; end
    pll_locked = 1'b0;
    repeat (3) begin
      tick();
      if (core_rst_n !== 1'b0) core_early = 1'b1;
      if (state_o === 3'd1) saw_wait = 1'b1;
    end
    pll_locked = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      if (state_o === 3'd1) saw_wait = 1'b1;
    end while (core_rst_n !== 1'b1 && n < 100);
    total++; if (saw_wait !== 1'b1) $display("FAIL glitch_wait_seen: got %b expected 1", saw_wait); else passed++;
    total++; if (core_early !== 1'b0) $display("FAIL glitch_core_pulse: got %b expected 0", core_early); else passed++;
    total++; if (n < 21 || n > 23) $display("FAIL glitch_fresh_window: got %0d expected 21..23", n); else passed++;
    total++; if (retry_cnt !== 8'd1) $display("FAIL glitch_retry: got %0d expected 1", retry_cnt); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    logic core_seen;
    core_seen = 1'b0;
    rst = 1'b0;
    pll_locked = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 20);
    total++; if (n != 4) $display("FAIL timeout_first_pulse: got %0d expected 4", n); else passed++;
    for (int i = 1; i <= 3; i++) begin
      n = 0;
      do begin tick(); n++; if (core_rst_n !== 1'b0) core_seen = 1'b1; end
      while (pll_rst !== 1'b1 && n < 100);
      total++; if (n != 50) $display("FAIL timeout_wait_len%0d: got %0d expected 50", i, n); else passed++;
      total++; if (retry_cnt !== 8'(i)) $display("FAIL timeout_retry%0d: got %0d expected %0d", i, retry_cnt, i); else passed++;
      n = 0;
      do begin tick(); n++; if (core_rst_n !== 1'b0) core_seen = 1'b1; end
      while (pll_rst !== 1'b0 && n < 20);
      total++; if (n != 4) $display("FAIL timeout_pulse_len%0d: got %0d expected 4", i, n); else passed++;
    end
    total++; if (core_seen !== 1'b0) $display("FAIL timeout_core: got %b expected 0", core_seen); else passed++;
  endtask

  task automatic test_saturation();
    logic [7:0] prev;
    logic wrapped;
    wrapped = 1'b0;
    prev = retry_cnt;
    repeat (260 * 54) begin
      tick();
      if (retry_cnt < prev) wrapped = 1'b1;
      prev = retry_cnt;
    end
    total++; if (retry_cnt !== 8'd255) $display("FAIL sat_value: got %0d expected 255", retry_cnt); else passed++;
    total++; if (wrapped !== 1'b0) $display("FAIL sat_wrap: got %b expected 0", wrapped); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_bringup();
    test_lock_loss_run();
    test_reset_mid();
    test_glitch_stabilize();
    test_timeout();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Power-on and lock-loss reset controller for the 100 MHz → 5 MHz/40 MHz clock generator.
- Runs on the free-running board reference clock, not on a PLL output, so it keeps running while the PLL is in reset.
- Drives the PLL's active-high reset input and consumes its asynchronous locked output.
- Produces staged, glitch-free reset releases for the core and peripheral logic, plus a timeout-and-retry loop when lock never arrives.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the locked synchroniser (legal range 2..4).
- PLL_RST_CYCLES, 16: refclk cycles that pll_rst is held high per attempt.
- LOCK_TIMEOUT_CYCLES, 100000: cycles allowed in WAIT_LOCK before retrying (1 ms at 100 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronised lock required before core release.
- CORE_TO_PERIPH_CYCLES, 64: cycles between core_rst_n and periph_rst_n release.
- CNT_W, 17: shared down-counter width; must hold the largest of the cycle parameters.

Ports:
- refclk  in  1  100 MHz free-running reference clock; sole clock.
- rst  in  1  synchronous, active-low reset, sampled on the refclk rising edge.
- pll_locked  in  1  PLL locked flag, asynchronous to refclk.
- pll_rst  out  1  active-high reset to the PLL rst input.
- core_rst_n  out  1  active-low core reset, refclk domain. Consumers re-synchronise it into outclk domains.
- periph_rst_n  out  1  active-low peripheral reset, refclk domain.
- ready  out  1  high only in RUN.
- state_o  out  3  current state encoding, for debug.
- retry_cnt  out  8  saturating count of lock timeouts plus lock losses.

Behaviour:
- While rst=0 at an edge:
  - state=PLL_RESET, pll_rst=1, core_rst_n=0, periph_rst_n=0, ready=0.
  - retry_cnt=0, synchroniser cleared to 0, counter=PLL_RST_CYCLES-1.
- lock_s is pll_locked after SYNC_STAGES flops. It is the only lock signal used by the FSM.
- All outputs are registered; no combinational path from any input to any output.
- PLL_RESET (0):
  - pll_rst=1; counter decrements each cycle.
  - At counter=0, go to WAIT_LOCK with counter=LOCK_TIMEOUT_CYCLES-1.
- WAIT_LOCK (1):
  - pll_rst=0.
  - If lock_s=1, go to STABILIZE with counter=LOCK_STABLE_CYCLES-1.
  - Otherwise, if counter=0, go to PLL_RESET with counter reloaded and retry_cnt incremented.
  - Otherwise decrement the counter.
  - If lock_s=1 and counter=0 occur together, lock wins.
- STABILIZE (2):
  - If lock_s=0, go to WAIT_LOCK, reload the timeout, increment retry_cnt.
  - Otherwise, at counter=0, go to CORE_UP: core_rst_n rises on that edge, counter=CORE_TO_PERIPH_CYCLES-1.
- CORE_UP (3):
  - core_rst_n=1.
  - At counter=0, go to RUN: periph_rst_n=1 and ready=1 on that edge.
- RUN (4): holds while lock_s=1.
- Lock loss in CORE_UP or RUN:
  - On the edge after lock_s falls: core_rst_n=0, periph_rst_n=0, ready=0.
  - Go to WAIT_LOCK, reload the timeout, increment retry_cnt. No PLL reset is issued; the PLL relocks on its own.
- Release ordering is invariant: periph_rst_n=1 implies core_rst_n=1, and core_rst_n=1 implies pll_rst=0.
- retry_cnt saturates at 255 and does not wrap.
- Encodings 5..7 are illegal. They are recovered to PLL_RESET with all resets asserted.
- rst taking effect mid-sequence restarts from PLL_RESET on the same edge, whatever the current state.
- Minimum lock-to-ready latency from the pll_locked rise, entered in WAIT_LOCK: SYNC_STAGES + LOCK_STABLE_CYCLES + CORE_TO_PERIPH_CYCLES + 1 cycles (±1 for synchroniser capture).

Decomposition:
- Shared clocking package holds:
  - the state enum, in the order PLL_RESET, WAIT_LOCK, STABILIZE, CORE_UP, RUN;
  - the STATE_W=3 constant;
  - the default cycle constants.
- One sub-module: bit_synchronizer (parameterised depth, synchronous active-low clear), used for pll_locked. The same module is reused elsewhere for re-synchronising resets into outclk domains.

Test Plan:
- Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=20, CORE_TO_PERIPH_CYCLES=8.
1. Normal bring-up:
   - Stimulus: rst low 3 cycles then high; pll_locked rises 10 cycles after pll_rst falls.
   - Response: pll_rst high exactly 4 cycles. core_rst_n rises 2+20 (±1) cycles after the pll_locked rise. periph_rst_n and ready rise 8 cycles after core_rst_n. retry_cnt=0.
2. Lock timeout:
   - Stimulus: pll_locked held 0.
   - Response: a pll_rst pulse of 4 cycles every 4+50 cycles; retry_cnt increments 1, 2, 3; core_rst_n stays 0.
3. Lock glitch in STABILIZE:
   - Stimulus: pll_locked drops for 3 cycles 10 cycles into STABILIZE.
   - Response: returns to WAIT_LOCK; retry_cnt=1; a fresh 20-cycle stabilise window starts on relock; core_rst_n never pulses high.
4. Lock loss in RUN:
   - Stimulus: drop pll_locked.
   - Response: all three outputs (core_rst_n, periph_rst_n, ready) go low within SYNC_STAGES+1 cycles; pll_rst stays 0; the full sequence repeats on relock; retry_cnt increments.
5. Reset mid-sequence:
   - Stimulus: rst=0 during CORE_UP.
   - Response: on the next edge, state_o=0, pll_rst=1, core_rst_n=0, retry_cnt=0.
6. Saturation:
   - Stimulus: force 260 timeouts.
   - Response: retry_cnt holds 255.
